// File: rtl/xfer_pkg.sv
// Shared definitions for the memory burst initiator: FSM encoding, direction codes, defaults.
// Pure declarations; no logic of its own.
// Imported by mem_xfer_master.
package xfer_pkg;

  // One-hot state encoding, 5 bits
  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_REQ     = 5'b00010,
    ST_WAIT_LO = 5'b00100,
    ST_WAIT_HI = 5'b01000,
    ST_FIN     = 5'b10000
  } state_e;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  localparam int TIMEOUT_DEFAULT    = 15;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  // Increment only the address bits selected by mask; the others stay fixed,
  // so the masked field wraps inside its window. Carry out of bit 23 is lost.
  function automatic logic [23:0] next_addr(input logic [23:0] a, input logic [23:0] m);
    return (a & ~m) | ((a + 24'd1) & m);
  endfunction

endpackage

// File: rtl/xfer_fifo.sv
// Byte FIFO with show-ahead output, synchronous flush and occupancy count.
// Latency: a pushed byte is visible on dout the cycle after the push.
// Backpressure: push while full and pop while empty are ignored; push+pop together both act.
module xfer_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full
);

  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rptr_q];
  assign count   = cnt_q;

  // Pointer and occupancy tracking; flush empties the queue without touching storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Byte storage; contents are only meaningful below the count, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/mem_xfer_master.sv
// Burst initiator: turns one (address, length, direction) command into single-byte arbiter requests.
// Latency: request strobe one cycle after REQ exit; each byte then waits on the arbiter rdy handshake.
// Backpressure: read requests stall while the read FIFO is full; writes stall until wr_valid.
module mem_xfer_master
  import xfer_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dir,
  input  logic [23:0] start_addr,
  input  logic [15:0] xfer_len,
  input  logic [23:0] addr_mask,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [23:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rrq,
  output logic        mem_wrq,
  input  logic        mem_rdy,
  input  logic [7:0]  mem_rdata
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [23:0]   addr_q;
  logic [23:0]   mask_q;
  logic [15:0]   rem_q;
  logic          dir_q;
  logic          abort_pend_q;
  logic          err_q;
  logic [TW-1:0] cnt_q;
  logic          mem_rrq_q;
  logic          mem_wrq_q;
  logic [7:0]    mem_wdata_q;

  logic          abort_any;
  logic          idle_start;
  logic          timeout_hit;
  logic          space_ok;
  logic          req_fire;
  logic          byte_done;
  logic          fifo_push;
  logic          fifo_flush;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;

  // An abort seen this cycle counts the same as one remembered from earlier
  assign abort_any   = abort | abort_pend_q;
  assign idle_start  = (state_q == ST_IDLE) && start;
  assign timeout_hit = (cnt_q == TW'(TIMEOUT - 1));
  assign space_ok    = (fifo_count < CW'(FIFO_DEPTH));

  assign error     = err_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rrq   = mem_rrq_q;
  assign mem_wrq   = mem_wrq_q;
  assign rd_valid  = ~fifo_empty;
  assign rd_data   = fifo_empty ? 8'h00 : fifo_dout;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic; an in-flight arbiter cycle is always allowed to finish
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = (xfer_len == 16'd0) ? ST_FIN : ST_REQ;
      end
      ST_REQ: begin
        if (abort_any)                              state_d = ST_FIN;
        else if (dir_q == DIR_READ && space_ok)     state_d = ST_WAIT_LO;
        else if (dir_q == DIR_WRITE && wr_valid)    state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!mem_rdy)         state_d = ST_WAIT_HI;
        else if (timeout_hit) state_d = ST_FIN;
      end
      ST_WAIT_HI: begin
        if (mem_rdy) state_d = (rem_q == 16'd1 || abort_any) ? ST_FIN : ST_REQ;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath strobes decoded from the current state
  always_comb begin
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_FIN);
    wr_ready   = (state_q == ST_REQ) && (dir_q == DIR_WRITE) && !abort_any;
    req_fire   = (state_q == ST_REQ) && (state_d == ST_WAIT_LO);
    byte_done  = (state_q == ST_WAIT_HI) && mem_rdy;
    fifo_push  = byte_done && (dir_q == DIR_READ) && !fifo_full;
    fifo_flush = idle_start;
  end

  // Command latch, address walk, request strobes, timeout counter and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      mask_q       <= '0;
      rem_q        <= '0;
      dir_q        <= DIR_READ;
      abort_pend_q <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      mem_rrq_q    <= 1'b0;
      mem_wrq_q    <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      mem_rrq_q <= req_fire && (dir_q == DIR_READ);
      mem_wrq_q <= req_fire && (dir_q == DIR_WRITE);
      if (req_fire && dir_q == DIR_WRITE) mem_wdata_q <= wr_data;

      if (idle_start) begin
        addr_q <= start_addr;
        rem_q  <= xfer_len;
        dir_q  <= dir;
        mask_q <= addr_mask;
        err_q  <= 1'b0;
      end else if (byte_done) begin
        addr_q <= next_addr(addr_q, mask_q);
        rem_q  <= rem_q - 16'd1;
      end

      if (req_fire)                                    cnt_q <= '0;
      else if (state_q == ST_WAIT_LO && mem_rdy)       cnt_q <= cnt_q + TW'(1);

      if (state_q == ST_WAIT_LO && mem_rdy && timeout_hit) err_q <= 1'b1;

      // start wins over a simultaneous abort; FIN retires any pending abort
      if (state_q == ST_FIN || idle_start) abort_pend_q <= 1'b0;
      else if (abort)                      abort_pend_q <= 1'b1;
    end
  end

  xfer_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (fifo_push),
    .pop   (rd_ready),
    .din   (mem_rdata),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule
